// File: rtl/interleaver_commutator.sv
// Input/output commutator for a convolutional byte interleaver: locks to the packet sync byte,
// strobes branches round-robin and collects the byte each branch pushes out.
module interleaver_commutator #(
  parameter int unsigned       BRANCHES  = 12,
  parameter int unsigned       DW        = 8,
  parameter int unsigned       PKT_LEN   = 204,
  parameter logic [DW-1:0]     SYNC_BYTE = 8'h47
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_valid,
  input  logic                   in_sync,
  output logic [BRANCHES-1:0]    branch_en,
  output logic [DW-1:0]          branch_data,
  input  logic [BRANCHES*DW-1:0] branch_q,
  output logic [DW-1:0]          out_data,
  output logic                   out_valid,
  output logic                   out_sync,
  output logic                   locked,
  output logic                   sync_err
);

  localparam int unsigned IdxW = (BRANCHES > 1) ? $clog2(BRANCHES) : 1;
  localparam int unsigned CntW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_sync_q, locked_q, sync_err_q;

  logic            is_sync, err, wr_en, wr_start;
  logic [IdxW-1:0] wr_idx;

  assign is_sync = in_sync && (in_data == SYNC_BYTE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err     = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    if (in_valid) begin
      if (state_q == StHunt) begin
        if (is_sync) begin
          state_d = StLocked;
          wr_en   = 1'b1;
          wr_idx  = '0;
          idx_d   = IdxW'(1);
          cnt_d   = CntW'(1);
        end
      end else begin
        err = (cnt_q == '0) ? !is_sync : in_sync;
        if (!err) begin
          wr_en = 1'b1;
          idx_d = (idx_q == IdxW'(BRANCHES - 1)) ? '0 : idx_q + 1'b1;
          cnt_d = (cnt_q == CntW'(PKT_LEN - 1)) ? '0 : cnt_q + 1'b1;
        end else if (is_sync) begin
          // A misplaced but genuine sync byte restarts the packet at once.
          wr_en  = 1'b1;
          wr_idx = '0;
          idx_d  = IdxW'(1);
          cnt_d  = CntW'(1);
        end else begin
          state_d = StHunt;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
    end
  end

  assign wr_start = wr_en && (wr_idx == '0) && (cnt_q == '0);

  always_comb begin
    branch_en = '0;
    if (wr_en && reset) begin
      branch_en[wr_idx] = 1'b1;
    end
  end

  assign branch_data = in_data;
  assign out_data_d  = wr_en ? branch_q[wr_idx*DW +: DW] : out_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StHunt;
      idx_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= wr_en;
      out_sync_q  <= wr_start;
      locked_q    <= (state_d == StLocked);
      sync_err_q  <= err;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sync  = out_sync_q;
  assign locked    = locked_q;
  assign sync_err  = sync_err_q;

endmodule
